// File: rtl/register_pipeline_variable_tracked.sv
// Run-time tap-selected delay line carrying a valid bit alongside every word.
// With SAFE_RETAP set, a tap change waits until every stage is empty so no word is skipped or repeated.
module register_pipeline_variable_tracked #(
    parameter int WORD_WIDTH = 8,
    parameter int PIPE_DEPTH = 8,
    parameter bit SAFE_RETAP = 1'b1,
    localparam int TAP_WIDTH = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  tap_number_load,
    input  logic [TAP_WIDTH-1:0]  tap_number,
    output logic [TAP_WIDTH-1:0]  tap_number_current,
    output logic                  tap_number_busy,
    input  logic                  shift_data,
    input  logic                  input_valid,
    input  logic [WORD_WIDTH-1:0] input_data,
    output logic                  output_valid,
    output logic [WORD_WIDTH-1:0] output_data
);

    localparam logic [TAP_WIDTH-1:0]  LAST_TAP_C  = TAP_WIDTH'(PIPE_DEPTH - 1);
    localparam logic [TAP_WIDTH-1:0]  ZERO_TAP_C  = {TAP_WIDTH{1'b0}};
    localparam logic [WORD_WIDTH-1:0] ZERO_WORD_C = {WORD_WIDTH{1'b0}};
    localparam logic [PIPE_DEPTH-1:0] ZERO_VLD_C  = {PIPE_DEPTH{1'b0}};

    typedef enum logic [0:0] {
        IDLE_S    = 1'b0,
        PENDING_S = 1'b1
    } retap_state_t;

    logic [WORD_WIDTH-1:0] data_r [PIPE_DEPTH];
    logic [PIPE_DEPTH-1:0] valid_r;
    logic [TAP_WIDTH-1:0]  tap_r;
    logic [TAP_WIDTH-1:0]  pending_tap_r;
    logic                  busy_r;
    retap_state_t          state_r;
    logic                  pipe_empty_s;

    // Requests beyond the last stage select the last stage (only reachable for non power-of-two depths).
    function automatic logic [TAP_WIDTH-1:0] clamp_tap(input logic [TAP_WIDTH-1:0] tap);
        logic [TAP_WIDTH-1:0] result;
        if ({1'b0, tap} > {1'b0, LAST_TAP_C}) begin
            result = LAST_TAP_C;
        end else begin
            result = tap;
        end
        return result;
    endfunction

    assign pipe_empty_s = (valid_r == ZERO_VLD_C);

    // Shift register of words and their valid bits; holds while shift_data is low.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                data_r[k] <= ZERO_WORD_C;
            end
            valid_r <= ZERO_VLD_C;
        end else if (clear) begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                data_r[k] <= ZERO_WORD_C;
            end
            valid_r <= ZERO_VLD_C;
        end else if (shift_data) begin
            for (int k = PIPE_DEPTH - 1; k > 0; k--) begin
                data_r[k]  <= data_r[k-1];
                valid_r[k] <= valid_r[k-1];
            end
            data_r[0]  <= input_data;
            valid_r[0] <= input_valid;
        end
    end

    // Tap control: immediate retap, or deferred until the pipeline is empty (sampled before this edge's shift).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE_S;
            tap_r         <= ZERO_TAP_C;
            pending_tap_r <= ZERO_TAP_C;
            busy_r        <= 1'b0;
        end else if (clear) begin
            state_r       <= IDLE_S;
            tap_r         <= ZERO_TAP_C;
            pending_tap_r <= ZERO_TAP_C;
            busy_r        <= 1'b0;
        end else if (!SAFE_RETAP) begin
            state_r <= IDLE_S;
            busy_r  <= 1'b0;
            if (tap_number_load) begin
                tap_r <= clamp_tap(tap_number);
            end
        end else begin
            case (state_r)
                IDLE_S: begin
                    if (tap_number_load) begin
                        pending_tap_r <= clamp_tap(tap_number);
                        state_r       <= PENDING_S;
                        busy_r        <= 1'b1;
                    end
                end
                PENDING_S: begin
                    // A fresh request restarts the wait; the last request wins.
                    if (tap_number_load) begin
                        pending_tap_r <= clamp_tap(tap_number);
                    end else if (pipe_empty_s) begin
                        tap_r   <= pending_tap_r;
                        state_r <= IDLE_S;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE_S;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign tap_number_current = tap_r;
    assign tap_number_busy    = busy_r;
    assign output_valid       = valid_r[tap_r];
    assign output_data        = data_r[tap_r];

endmodule

// File: tb/tb_register_pipeline_variable_tracked.sv
// Directed bench for register_pipeline_variable_tracked: safe-retap, immediate-retap and depth-6 instances share stimulus.
module tb_register_pipeline_variable_tracked;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [2:0] tap = 3'd0;
    logic       shift = 1'b0;
    logic       vin = 1'b0;
    logic [7:0] din = 8'd0;

    logic [2:0] s_tap, i_tap, d6_tap;
    logic       s_busy, i_busy, d6_busy;
    logic       s_valid, i_valid, d6_valid;
    logic [7:0] s_data, i_data, d6_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       load;
        logic [2:0] tap;
        logic       shift;
        logic       vin;
        logic [7:0] din;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic [2:0] exp_tap;
        logic       exp_busy;
    } vec_t;

    vec_t vecs [12];

    register_pipeline_variable_tracked #(.WORD_WIDTH(8), .PIPE_DEPTH(8), .SAFE_RETAP(1'b1)) dut_s (
        .clock(clock), .reset(reset), .clear(clear), .tap_number_load(load), .tap_number(tap),
        .tap_number_current(s_tap), .tap_number_busy(s_busy), .shift_data(shift),
        .input_valid(vin), .input_data(din), .output_valid(s_valid), .output_data(s_data));

    register_pipeline_variable_tracked #(.WORD_WIDTH(8), .PIPE_DEPTH(8), .SAFE_RETAP(1'b0)) dut_i (
        .clock(clock), .reset(reset), .clear(clear), .tap_number_load(load), .tap_number(tap),
        .tap_number_current(i_tap), .tap_number_busy(i_busy), .shift_data(shift),
        .input_valid(vin), .input_data(din), .output_valid(i_valid), .output_data(i_data));

    register_pipeline_variable_tracked #(.WORD_WIDTH(8), .PIPE_DEPTH(6), .SAFE_RETAP(1'b0)) dut_6 (
        .clock(clock), .reset(reset), .clear(clear), .tap_number_load(load), .tap_number(tap),
        .tap_number_current(d6_tap), .tap_number_busy(d6_busy), .shift_data(shift),
        .input_valid(vin), .input_data(din), .output_valid(d6_valid), .output_data(d6_data));

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic l, input logic [2:0] t, input logic sh, input logic v, input logic [7:0] d);
        load  = l;
        tap   = t;
        shift = sh;
        vin   = v;
        din   = d;
    endtask

    task automatic do_reset();
        drive(1'b0, 3'd0, 1'b0, 1'b0, 8'd0);
        clear = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    logic       exp_v9 [9];
    logic [7:0] exp_d9 [9];
    int         shifts;

    initial begin
        // Latency table: safe instance, tap 3 loaded into an empty pipe, ramp 1..6 then bubbles.
        vecs[0]  = '{1'b1, 3'd3, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 3'd0, 1'b1};
        vecs[1]  = '{1'b0, 3'd0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 3'd3, 1'b0};
        vecs[2]  = '{1'b0, 3'd0, 1'b1, 1'b1, 8'd1, 1'b0, 8'd0, 3'd3, 1'b0};
        vecs[3]  = '{1'b0, 3'd0, 1'b1, 1'b1, 8'd2, 1'b0, 8'd0, 3'd3, 1'b0};
        vecs[4]  = '{1'b0, 3'd0, 1'b1, 1'b1, 8'd3, 1'b0, 8'd0, 3'd3, 1'b0};
        vecs[5]  = '{1'b0, 3'd0, 1'b1, 1'b1, 8'd4, 1'b1, 8'd1, 3'd3, 1'b0};
        vecs[6]  = '{1'b0, 3'd0, 1'b1, 1'b1, 8'd5, 1'b1, 8'd2, 3'd3, 1'b0};
        vecs[7]  = '{1'b0, 3'd0, 1'b1, 1'b1, 8'd6, 1'b1, 8'd3, 3'd3, 1'b0};
        vecs[8]  = '{1'b0, 3'd0, 1'b1, 1'b0, 8'd0, 1'b1, 8'd4, 3'd3, 1'b0};
        vecs[9]  = '{1'b0, 3'd0, 1'b1, 1'b0, 8'd0, 1'b1, 8'd5, 3'd3, 1'b0};
        vecs[10] = '{1'b0, 3'd0, 1'b1, 1'b0, 8'd0, 1'b1, 8'd6, 3'd3, 1'b0};
        vecs[11] = '{1'b0, 3'd0, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 3'd3, 1'b0};

        // Safe retap drain at tap 5: W1..W4 leave at their old latency, switch to tap 1 on bubble 9.
        exp_v9 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_d9 = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};

        // Reset state, before any clock edge.
        #1;
        check("rst_tap", s_tap, 3'd0);
        check("rst_busy", s_busy, 1'b0);
        check("rst_valid", s_valid, 1'b0);
        check("rst_data", s_data, 8'd0);
        do_reset();

        for (int n = 0; n < 12; n++) begin
            drive(vecs[n].load, vecs[n].tap, vecs[n].shift, vecs[n].vin, vecs[n].din);
            step();
            check($sformatf("lat%0d_valid", n), s_valid, vecs[n].exp_valid);
            check($sformatf("lat%0d_data", n), s_data, vecs[n].exp_data);
            check($sformatf("lat%0d_tap", n), s_tap, vecs[n].exp_tap);
            check($sformatf("lat%0d_busy", n), s_busy, vecs[n].exp_busy);
        end

        // Stalled shift on the immediate instance, tap 2.
        do_reset();
        drive(1'b1, 3'd2, 1'b0, 1'b0, 8'd0);
        step();
        check("stall_tap", i_tap, 3'd2);
        check("stall_busy", i_busy, 1'b0);
        drive(1'b0, 3'd0, 1'b1, 1'b1, 8'hA1);
        step();
        drive(1'b0, 3'd0, 1'b1, 1'b1, 8'hB2);
        step();
        check("stall_push_valid", i_valid, 1'b0);
        drive(1'b0, 3'd0, 1'b0, 1'b1, 8'hFF);
        for (int n = 0; n < 5; n++) begin
            step();
            check($sformatf("stall_hold%0d", n), i_valid, 1'b0);
        end
        drive(1'b0, 3'd0, 1'b1, 1'b0, 8'd0);
        step();
        check("stall_a_valid", i_valid, 1'b1);
        check("stall_a_data", i_data, 8'hA1);
        step();
        check("stall_b_data", i_data, 8'hB2);

        // Clamp: depth 8 takes tap 7 (latency 8), depth 6 clamps 7 to 5 (latency 6).
        do_reset();
        drive(1'b1, 3'd7, 1'b0, 1'b0, 8'd0);
        step();
        check("clamp_tap8", i_tap, 3'd7);
        check("clamp_tap6", d6_tap, 3'd5);
        for (int n = 1; n <= 8; n++) begin
            drive(1'b0, 3'd0, 1'b1, (n == 1), (n == 1) ? 8'h5C : 8'h00);
            step();
            check($sformatf("clamp6_v%0d", n), d6_valid, (n == 6));
            check($sformatf("clamp8_v%0d", n), i_valid, (n == 8));
            if (n == 6) check("clamp6_data", d6_data, 8'h5C);
            if (n == 8) check("clamp8_data", i_data, 8'h5C);
        end

        // Safe retap versus immediate retap.
        do_reset();
        drive(1'b1, 3'd5, 1'b0, 1'b0, 8'd0);
        step();
        check("empty_busy_hi", s_busy, 1'b1);
        check("empty_tap_old", s_tap, 3'd0);
        drive(1'b0, 3'd0, 1'b0, 1'b0, 8'd0);
        step();
        check("empty_busy_lo", s_busy, 1'b0);
        check("empty_tap_new", s_tap, 3'd5);
        for (int n = 1; n <= 4; n++) begin
            drive(1'b0, 3'd0, 1'b1, 1'b1, 8'(n * 8'h11));
            step();
        end
        drive(1'b1, 3'd1, 1'b0, 1'b0, 8'd0);
        step();
        check("safe_busy", s_busy, 1'b1);
        check("safe_tap_held", s_tap, 3'd5);
        check("imm_tap", i_tap, 3'd1);
        check("imm_busy", i_busy, 1'b0);
        check("imm_valid", i_valid, 1'b1);
        check("imm_data", i_data, 8'h33);
        for (int n = 0; n < 9; n++) begin
            drive(1'b0, 3'd0, 1'b1, 1'b0, 8'd0);
            step();
            check($sformatf("drain%0d_valid", n), s_valid, exp_v9[n]);
            check($sformatf("drain%0d_data", n), s_data, exp_d9[n]);
            check($sformatf("drain%0d_busy", n), s_busy, (n < 8));
            check($sformatf("drain%0d_tap", n), s_tap, (n < 8) ? 3'd5 : 3'd1);
        end
        drive(1'b0, 3'd0, 1'b1, 1'b1, 8'h99);
        step();
        check("new_word_early", s_valid, 1'b0);
        drive(1'b0, 3'd0, 1'b1, 1'b0, 8'd0);
        step();
        check("new_word_valid", s_valid, 1'b1);
        check("new_word_data", s_data, 8'h99);

        // Last pending request wins; one word in stage 0 drains after 9 shifts.
        do_reset();
        drive(1'b0, 3'd0, 1'b1, 1'b1, 8'h77);
        step();
        check("lw_out_data", s_data, 8'h77);
        drive(1'b1, 3'd6, 1'b0, 1'b0, 8'd0);
        step();
        drive(1'b1, 3'd2, 1'b0, 1'b0, 8'd0);
        step();
        check("lw_busy", s_busy, 1'b1);
        check("lw_tap_old", s_tap, 3'd0);
        drive(1'b0, 3'd0, 1'b1, 1'b0, 8'd0);
        shifts = 0;
        while (s_busy && shifts < 20) begin
            step();
            shifts++;
        end
        check("lw_shifts", shifts, 9);
        check("lw_tap", s_tap, 3'd2);

        // Asynchronous reset while a retap is pending.
        do_reset();
        drive(1'b0, 3'd0, 1'b1, 1'b1, 8'h42);
        step();
        drive(1'b1, 3'd4, 1'b0, 1'b0, 8'd0);
        step();
        check("ar_pre_busy", s_busy, 1'b1);
        drive(1'b0, 3'd0, 1'b0, 1'b0, 8'd0);
        #2 reset = 1'b1;
        #1;
        check("ar_busy", s_busy, 1'b0);
        check("ar_tap", s_tap, 3'd0);
        check("ar_valid", s_valid, 1'b0);
        check("ar_imm_tap", i_tap, 3'd0);
        #1 reset = 1'b0;

        // Synchronous clear beats a simultaneous load and shift.
        drive(1'b0, 3'd0, 1'b1, 1'b1, 8'h42);
        step();
        drive(1'b1, 3'd4, 1'b0, 1'b0, 8'd0);
        step();
        check("cl_pre_busy", s_busy, 1'b1);
        clear = 1'b1;
        drive(1'b1, 3'd4, 1'b1, 1'b1, 8'hEE);
        step();
        clear = 1'b0;
        check("cl_busy", s_busy, 1'b0);
        check("cl_tap", s_tap, 3'd0);
        check("cl_valid", s_valid, 1'b0);
        check("cl_imm_tap", i_tap, 3'd0);
        drive(1'b0, 3'd0, 1'b0, 1'b0, 8'd0);
        step();
        check("cl_post_busy", s_busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
